// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage FSM states and shared constants
package fetch_pkg;
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_FULL} state_t;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam int PC_INC = 4;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush (highest priority), hold and load
// ports: clk, reset (async), flush, hold, load, ld_pc/ld_instr in; valid, pc, instr out
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                hold,
   input  logic                load,
   input  logic [PC_WIDTH-1:0] ld_pc,
   input  logic [31:0]         ld_instr,
   output logic                valid,
   output logic [PC_WIDTH-1:0] pc,
   output logic [31:0]         instr
);
   // a flush leaves pc untouched; only valid and instr are cleared
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load && !hold) begin
         valid <= 1'b1;
         pc    <= ld_pc;
         instr <= ld_instr;
      end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem fetch, one-entry skid and IF/ID drive
// ports: clk, reset (async), PCSel/PCBranch redirect, stall in;
//        imem_req_valid/imem_addr out, imem_req_ready, imem_rsp_valid/imem_rsp_data in;
//        if_id_valid/if_id_pc/if_id_instr out
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH = 9,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                PCSel,
   input  logic [31:0]         PCBranch,
   input  logic                stall,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_rsp_valid,
   input  logic [31:0]         imem_rsp_data,
   output logic                if_id_valid,
   output logic [PC_WIDTH-1:0] if_id_pc,
   output logic [31:0]         if_id_instr
);
   state_t              state, state_n;
   logic [PC_WIDTH-1:0] pc_q, skid_pc;
   logic [31:0]         skid_instr;
   logic                rsp_take;
   logic                unused_branch_hi;
   assign unused_branch_hi = ^PCBranch[31:PC_WIDTH];
   assign rsp_take = state == S_WAIT && imem_rsp_valid;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_REQ;
      else       state <= state_n;
   // a redirect with a response still owed goes to S_DROP so that response is swallowed
   always_comb begin
      state_n = state;
      if (PCSel)
         state_n = ((state == S_WAIT || state == S_DROP) && !imem_rsp_valid) ? S_DROP : S_REQ;
      else
         case (state)
            S_REQ:   state_n = (imem_req_valid && imem_req_ready) ? S_WAIT : S_REQ;
            S_WAIT:  state_n = imem_rsp_valid ? (stall ? S_FULL : S_REQ) : S_WAIT;
            S_DROP:  state_n = imem_rsp_valid ? S_REQ : S_DROP;
            default: state_n = stall ? S_FULL : S_REQ;
         endcase
   end
   always_comb begin
      imem_req_valid = state == S_REQ && !stall && !PCSel && !reset;
      imem_addr      = pc_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset)         pc_q <= RESET_PC;
      else if (PCSel)    pc_q <= PCBranch[PC_WIDTH-1:0];
      else if (rsp_take) pc_q <= pc_q + PC_WIDTH'(PC_INC);
   // skid occupancy is implied by S_FULL, so leaving S_FULL empties it
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         skid_pc    <= '0;
         skid_instr <= NOP_INSTR;
      end else if (rsp_take && stall && !PCSel) begin
         skid_pc    <= pc_q;
         skid_instr <= imem_rsp_data;
      end
   if_id_reg #(.PC_WIDTH(PC_WIDTH)) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .flush    (PCSel),
      .hold     (stall),
      .load     (rsp_take || state == S_FULL),
      .ld_pc    (state == S_FULL ? skid_pc : pc_q),
      .ld_instr (state == S_FULL ? skid_instr : imem_rsp_data),
      .valid    (if_id_valid),
      .pc       (if_id_pc),
      .instr    (if_id_instr)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a transaction-level model
module tb_fetch_stage;
   import fetch_pkg::*;
   localparam int PW = 9;
   logic          clk = 1'b0, reset = 1'b1, PCSel = 1'b0, stall = 1'b0;
   logic          imem_req_ready = 1'b1, imem_rsp_valid = 1'b0;
   logic [31:0]   PCBranch = '0, imem_rsp_data = '0;
   logic          imem_req_valid, if_id_valid;
   logic [PW-1:0] imem_addr, if_id_pc;
   logic [31:0]   if_id_instr;
   int total = 0, bad = 0;
   int lat = 1, mem_cnt = -1, accepts = 0, overlap = 0;
   logic [PW-1:0] mem_a;
   logic [PW-1:0] m_pc, m_ifpc;
   logic          m_v, m_busy, m_discard;
   logic [31:0]   m_instr;
   logic [PW+31:0] held[$];
   logic          e_req, o_req;
   logic [PW-1:0] e_addr, o_addr;
   always #5 clk = ~clk;
   fetch_stage #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
      .clk(clk), .reset(reset), .PCSel(PCSel), .PCBranch(PCBranch), .stall(stall),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
   );
   function automatic logic [31:0] mem_data(input logic [PW-1:0] a);
      return 32'h1000_0003 + 32'(a) * 32'h0001_0101;
   endfunction
   task automatic model_init();
      m_pc = '0; m_ifpc = '0; m_v = 1'b0; m_instr = NOP_INSTR;
      m_busy = 1'b0; m_discard = 1'b0; held.delete(); mem_cnt = -1;
   endtask
   // one clock: memory answers, outputs are sampled, model advances, then edge + 1
   task automatic tick();
      logic rsp_now;
      if (mem_cnt > 0) mem_cnt--;
      rsp_now = mem_cnt == 0;
      imem_rsp_valid = rsp_now;
      imem_rsp_data = rsp_now ? mem_data(mem_a) : $urandom;
      if (rsp_now) mem_cnt = -1;
      #1;
      o_req = imem_req_valid;
      o_addr = imem_addr;
      e_req = !m_busy && !m_discard && held.size() == 0 && !stall && !PCSel;
      e_addr = m_pc;
      if (o_req && imem_req_ready) begin
         if (mem_cnt >= 0) overlap++;
         accepts++;
         mem_cnt = lat;
         mem_a = o_addr;
      end
      if (PCSel) begin
         m_discard = (m_busy || m_discard) && !rsp_now;
         m_busy = 1'b0;
         m_pc = PCBranch[PW-1:0];
         m_v = 1'b0;
         m_instr = NOP_INSTR;
         held.delete();
      end else begin
         if (rsp_now && m_discard) m_discard = 1'b0;
         else if (rsp_now && m_busy) begin
            m_busy = 1'b0;
            if (stall) held.push_back({m_pc, imem_rsp_data});
            else begin m_v = 1'b1; m_ifpc = m_pc; m_instr = imem_rsp_data; end
            m_pc = m_pc + PW'(4);
         end else if (held.size() != 0 && !stall) begin
            {m_ifpc, m_instr} = held.pop_front();
            m_v = 1'b1;
         end
         if (e_req && imem_req_ready) m_busy = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; imem_req_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req_valid); end
      total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL rst_addr got=%h want=000", imem_addr); end
      total++; if (if_id_valid !== 1'b0 || if_id_pc !== 9'h000 || if_id_instr !== 32'h00000013) begin
         bad++; $display("FAIL rst_ifid got=%b/%h/%h want=0/000/00000013", if_id_valid, if_id_pc, if_id_instr); end
      reset = 1'b0;
      model_init();
   endtask
   task automatic test_sequential();
      lat = 1;
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h000) begin bad++; $display("FAIL seq_req0 got=%b/%h want=1/000", o_req, o_addr); end
      tick();
      total++; if (if_id_valid !== 1'b1 || if_id_pc !== 9'h000 || if_id_instr !== mem_data(9'h000)) begin
         bad++; $display("FAIL seq_ifid0 got=%b/%h/%h want=1/000/%h", if_id_valid, if_id_pc, if_id_instr, mem_data(9'h000)); end
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h004) begin bad++; $display("FAIL seq_req4 got=%b/%h want=1/004", o_req, o_addr); end
      tick();
      total++; if (if_id_pc !== 9'h004 || if_id_instr !== mem_data(9'h004)) begin
         bad++; $display("FAIL seq_ifid4 got=%h/%h want=004/%h", if_id_pc, if_id_instr, mem_data(9'h004)); end
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h008) begin bad++; $display("FAIL seq_req8 got=%b/%h want=1/008", o_req, o_addr); end
   endtask
   task automatic test_stall_skid();
      stall = 1'b1;
      tick();
      total++; if (if_id_valid !== 1'b1 || if_id_pc !== 9'h004) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/004", if_id_valid, if_id_pc); end
      tick();
      total++; if (o_req !== 1'b0 || if_id_pc !== 9'h004) begin bad++; $display("FAIL stall_noreq got=%b/%h want=0/004", o_req, if_id_pc); end
      stall = 1'b0;
      tick();
      total++; if (if_id_pc !== 9'h008 || if_id_instr !== mem_data(9'h008)) begin
         bad++; $display("FAIL skid_drain got=%h/%h want=008/%h", if_id_pc, if_id_instr, mem_data(9'h008)); end
      lat = 3;
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h00C) begin bad++; $display("FAIL skid_next got=%b/%h want=1/00c", o_req, o_addr); end
   endtask
   task automatic test_redirect_wait();
      PCSel = 1'b1; PCBranch = 32'h40;
      tick();
      PCSel = 1'b0;
      total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP_INSTR) begin bad++; $display("FAIL rw_flush got=%b/%h want=0/00000013", if_id_valid, if_id_instr); end
      tick();
      total++; if (o_req !== 1'b0) begin bad++; $display("FAIL rw_noreq1 got=%b want=0", o_req); end
      tick();
      total++; if (o_req !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL rw_drop got=%b/%b want=0/0", o_req, if_id_valid); end
      lat = 2;
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h040) begin bad++; $display("FAIL rw_target got=%b/%h want=1/040", o_req, o_addr); end
   endtask
   task automatic test_redirect_same_cycle();
      tick();
      PCSel = 1'b1; PCBranch = 32'h80;
      tick();
      PCSel = 1'b0;
      total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rs_flush got=%b want=0", if_id_valid); end
      lat = 1;
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h080) begin bad++; $display("FAIL rs_target got=%b/%h want=1/080", o_req, o_addr); end
   endtask
   task automatic test_redirect_skid();
      stall = 1'b1;
      tick();
      total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rk_hold got=%b want=0", if_id_valid); end
      PCSel = 1'b1; PCBranch = 32'hC0;
      tick();
      PCSel = 1'b0;
      total++; if (o_req !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL rk_flush got=%b/%b want=0/0", o_req, if_id_valid); end
      tick();
      total++; if (o_req !== 1'b0) begin bad++; $display("FAIL rk_stallreq got=%b want=0", o_req); end
      stall = 1'b0;
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h0C0 || if_id_valid !== 1'b0) begin
         bad++; $display("FAIL rk_target got=%b/%h/%b want=1/0c0/0", o_req, o_addr, if_id_valid); end
      tick();
      total++; if (if_id_valid !== 1'b1 || if_id_pc !== 9'h0C0) begin bad++; $display("FAIL rk_load got=%b/%h want=1/0c0", if_id_valid, if_id_pc); end
   endtask
   task automatic test_wrap();
      PCSel = 1'b1; PCBranch = 32'h1FC;
      tick();
      PCSel = 1'b0;
      total++; if (o_req !== 1'b0) begin bad++; $display("FAIL wrap_gate got=%b want=0", o_req); end
      tick();
      total++; if (o_req !== 1'b1 || o_addr !== 9'h1FC) begin bad++; $display("FAIL wrap_req got=%b/%h want=1/1fc", o_req, o_addr); end
      tick();
      total++; if (if_id_pc !== 9'h1FC || if_id_instr !== mem_data(9'h1FC)) begin
         bad++; $display("FAIL wrap_ifid got=%h/%h want=1fc/%h", if_id_pc, if_id_instr, mem_data(9'h1FC)); end
   endtask
   task automatic test_ready_low();
      int a0;
      a0 = accepts;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (o_req !== 1'b1 || o_addr !== 9'h000) begin bad++; $display("FAIL rdy_stable[%0d] got=%b/%h want=1/000", i, o_req, o_addr); end
      end
      imem_req_ready = 1'b1;
      tick();
      tick();
      total++; if (accepts - a0 !== 1) begin bad++; $display("FAIL rdy_accepts got=%0d want=1", accepts - a0); end
      total++; if (if_id_valid !== 1'b1 || if_id_pc !== 9'h000) begin bad++; $display("FAIL rdy_ifid got=%b/%h want=1/000", if_id_valid, if_id_pc); end
   endtask
   task automatic test_random();
      logic prev_sel;
      prev_sel = 1'b0;
      for (int i = 0; i < 800; i++) begin
         stall = $urandom_range(0, 3) == 0;
         PCSel = !prev_sel && $urandom_range(0, 11) == 0;
         PCBranch = ($urandom_range(0, 7) == 0) ? 32'h1FC : ($urandom & 32'h0000_01FC);
         imem_req_ready = $urandom_range(0, 2) != 0;
         prev_sel = PCSel;
         lat = $urandom_range(1, 4);
         tick();
         total++; if (o_req !== e_req || (e_req && o_addr !== e_addr)) begin
            bad++; $display("FAIL rnd_req[%0d] got=%b/%h want=%b/%h", i, o_req, o_addr, e_req, e_addr); end
         total++; if (if_id_valid !== m_v || if_id_pc !== m_ifpc || if_id_instr !== m_instr) begin
            bad++; $display("FAIL rnd_ifid[%0d] got=%b/%h/%h want=%b/%h/%h", i, if_id_valid, if_id_pc, if_id_instr, m_v, m_ifpc, m_instr); end
      end
      PCSel = 1'b0; stall = 1'b0;
      total++; if (overlap !== 0) begin bad++; $display("FAIL outstanding got=%0d want=0", overlap); end
   endtask
   initial begin
      test_reset();
      test_sequential();
      test_stall_skid();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_redirect_skid();
      test_wrap();
      test_ready_low();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits upstream of the branch unit and consumes its PCSel/PCBranch redirect. It owns the PC register, issues one-outstanding-request fetches to a variable-latency instruction memory, buffers one response against decode stalls, and drives the IF/ID pipeline register. A taken branch from EX squashes wrong-path work, including a response still in flight.

Parameters:
PC_WIDTH, 9, byte-address width of the PC and the instruction-memory address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
PCSel  in  1  branch/jump taken; single-cycle pulse from the branch unit
PCBranch  in  32  redirect target; bits [PC_WIDTH-1:0] are used
stall  in  1  hazard unit: hold IF/ID and do not advance
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request
imem_addr  out  PC_WIDTH  fetch address (the current pc_q)
imem_rsp_valid  in  1  response valid; one cycle, in order
imem_rsp_data  in  32  fetched instruction
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  PC_WIDTH  PC of the IF/ID instruction
if_id_instr  out  32  instruction to decode

Behaviour:
- Reset (async, any state):
  - pc_q=RESET_PC, state=S_REQ.
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP (32'h00000013).
  - Skid buffer empty; imem_req_valid=0 during reset.
- States: S_REQ, S_WAIT, S_DROP, S_FULL.
- S_REQ:
  - imem_req_valid = !stall && !PCSel; imem_addr = pc_q.
  - On valid && ready -> S_WAIT. Otherwise stay.
- S_WAIT, rsp_valid, no stall:
  - IF/ID <= {1, pc_q, rsp_data}.
  - pc_q <= pc_q+4, truncated to PC_WIDTH with wrap.
  - -> S_REQ.
- S_WAIT, rsp_valid with stall:
  - Skid <= {pc_q, rsp_data}; pc_q <= pc_q+4; IF/ID holds.
  - -> S_FULL.
- S_FULL: when stall drops, IF/ID <= skid, then -> S_REQ. Every output holds while stalled.
- Stall with no new data: IF/ID holds all fields unchanged.
- Redirect (PCSel=1) has priority over stall and over response acceptance:
  - pc_q <= PCBranch[PC_WIDTH-1:0].
  - IF/ID flushed: valid=0, instr=NOP.
  - Skid emptied.
  - From S_WAIT without rsp_valid that cycle -> S_DROP.
  - From S_WAIT with rsp_valid that same cycle -> S_REQ; the response is discarded.
  - From S_REQ or S_FULL -> S_REQ.
- Redirect request gating: no request is issued in the PCSel cycle; the first target fetch is the next cycle.
- S_DROP:
  - No request is issued.
  - The next rsp_valid is discarded -> S_REQ.
  - A second PCSel while in S_DROP updates pc_q and stays in S_DROP.
- Latency: minimum 2 cycles from request acceptance to IF/ID update with a 1-cycle memory. Throughput is one instruction per 2 cycles; no pipelined requests.
- Outstanding requests: at most one at any time; imem_req_valid=0 in S_WAIT, S_DROP and S_FULL.
- Request stability: once asserted in S_REQ, imem_req_valid and imem_addr hold until ready, unless a redirect arrives.

Decomposition:
- fetch_pkg:
  - state enum (S_REQ, S_WAIT, S_DROP, S_FULL).
  - NOP_INSTR = 32'h00000013.
  - PC_INC = 4.
- Sub-module if_id_reg: holds valid/pc/instr, with load, flush (priority) and hold inputs.
- FSM, pc_q and skid live in fetch_stage.

Test Plan:
- Reset release, 1-cycle memory, no stall -> addresses 0,4,8 are requested. IF/ID shows pc 0,4,8 with memory data, each 2 cycles apart.
- stall=1 asserted while the response for pc=8 arrives:
  - IF/ID keeps pc 4; no new request.
  - Release stall -> IF/ID shows pc 8 next cycle, then fetch of 12.
- PCSel=1, PCBranch=0x40, while in S_WAIT for pc=12 (latency 3):
  - IF/ID is flushed to NOP/valid=0.
  - The late response for 12 is dropped.
  - The next request is 0x40.
- PCSel in the same cycle as rsp_valid -> response discarded, next request at target, no S_DROP.
- PCSel with stall=1 and skid full -> skid cleared, IF/ID flushed, request at target once stall drops.
- Wrap-around: pc=0x1FC (PC_WIDTH=9) accepted -> next request address 0x000.
- imem_req_ready held low 5 cycles -> request and address remain stable, and exactly one request is accepted.
